// File: rtl/mdu_defs_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, default
// latencies and counter width. MDU_MADD_EN enables the madd/msub launch codes.
package mdu_defs;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MADD  = 3'd6,
        MD_MSUB  = 3'd7
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 4;

    // Operations that occupy the unit when launched with start.
    function automatic logic is_launch_op(input md_op_e op);
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: is_launch_op = 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MSUB:                   is_launch_op = 1'b1;
`endif
            default:                            is_launch_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input md_op_e op);
        is_div_op = (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath: 64-bit product, quotient/remainder or accumulate
// result for one operation; write_en low when the result must be discarded.
module mdu_arith
    import mdu_defs::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result,
    output logic        write_en
);

    logic signed [63:0] a_ext, b_ext, prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] a_mag, b_mag, dividend, divisor;
    logic        [31:0] quo_u, rem_u, quo, rem;
    logic               div_signed;

    assign a_ext  = {{32{a[31]}}, a};
    assign b_ext  = {{32{b[31]}}, b};
    assign prod_s = a_ext * b_ext;
    assign prod_u = {32'h0, a} * {32'h0, b};

    // Signed divide runs on magnitudes; 0x80000000 / -1 then falls out as
    // quotient 0x80000000, remainder 0 without a special case.
    assign div_signed = (op == MD_DIV);
    assign a_mag      = a[31] ? (~a + 32'd1) : a;
    assign b_mag      = b[31] ? (~b + 32'd1) : b;
    assign dividend   = div_signed ? a_mag : a;
    assign divisor    = div_signed ? b_mag : b;
    assign quo_u      = (divisor == 32'd0) ? 32'd0 : dividend / divisor;
    assign rem_u      = (divisor == 32'd0) ? 32'd0 : dividend % divisor;
    assign quo        = (div_signed && (a[31] ^ b[31])) ? (~quo_u + 32'd1) : quo_u;
    assign rem        = (div_signed && a[31]) ? (~rem_u + 32'd1) : rem_u;

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        result   = 64'd0;
        write_en = 1'b0;
        case (op)
            MD_MULT: begin
                result   = prod_s;
                write_en = 1'b1;
            end
            MD_MULTU: begin
                result   = prod_u;
                write_en = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
                result   = {rem, quo};
                write_en = (b != 32'd0);
            end
            MD_MADD: begin
                result   = {hi, lo} + prod_s;
                write_en = 1'b1;
            end
            MD_MSUB: begin
                result   = {hi, lo} - prod_s;
                write_en = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit holding HI/LO; results land after a fixed
// latency. Define MDU_MADD_EN to enable madd/msub.
module mult_div_unit
    import mdu_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

    md_op_e           op;
    logic [CNT_W-1:0] counter;
    logic [63:0]      shadow;
    logic             shadow_wr;
    logic [63:0]      arith_result;
    logic             arith_wr;
    logic             accept;

    assign op     = md_op_e'(MDop);
    assign accept = start && !busy && is_launch_op(op);

    mdu_arith u_arith (
        .op       (op),
        .a        (A),
        .b        (B),
        .hi       (HI),
        .lo       (LO),
        .result   (arith_result),
        .write_en (arith_wr)
    );

    // The result is captured at accept and held in the shadow until the
    // counter expires, so HI/LO never show a value early.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            busy      <= 1'b0;
            counter   <= '0;
            shadow    <= 64'd0;
            shadow_wr <= 1'b0;
            HI        <= 32'd0;
            LO        <= 32'd0;
        end else if (busy) begin
            counter <= counter - 1'b1;
            if (counter == CNT_W'(1)) begin
                busy <= 1'b0;
                if (shadow_wr) begin
                    {HI, LO} <= shadow;
                end
            end
        end else if (accept) begin
            shadow    <= arith_result;
            shadow_wr <= arith_wr;
            counter   <= is_div_op(op) ? DIV_CNT : MULT_CNT;
            busy      <= 1'b1;
        end else if (op == MD_MTHI) begin
            HI <= A;
        end else if (op == MD_MTLO) begin
            LO <= A;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: spec vector table, hand-written
// corner sequences and randomized ops against an arithmetic reference model.
module tb_mult_div_unit;

`ifdef MDU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  MDop;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } vec_t;

    vec_t vecs[8];

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .MDop  (MDop),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: architectural effect of one issued op, in plain arithmetic.
    function automatic void model(input logic [2:0] op, input bit st,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] hi, input logic [31:0] lo,
                                  output logic [31:0] nhi, output logic [31:0] nlo,
                                  output int cyc);
        longint      sa, sb, q, r;
        logic [63:0] acc;
        nhi = hi;
        nlo = lo;
        cyc = 0;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        if (op == 3'd4) nhi = a;
        else if (op == 3'd5) nlo = a;
        else if (st) begin
            case (op)
                3'd0: begin acc = sa * sb; {nhi, nlo} = acc; cyc = 5; end
                3'd1: begin acc = {32'h0, a} * {32'h0, b}; {nhi, nlo} = acc; cyc = 5; end
                3'd2: begin
                    cyc = 10;
                    if (b != 32'd0) begin
                        q = sa / sb;
                        r = sa % sb;
                        nlo = q[31:0];
                        nhi = r[31:0];
                    end
                end
                3'd3: begin
                    cyc = 10;
                    if (b != 32'd0) begin
                        nlo = a / b;
                        nhi = a % b;
                    end
                end
                3'd6, 3'd7: begin
                    if (MADD_EN) begin
                        acc = (op == 3'd6) ? ({hi, lo} + 64'(sa * sb)) : ({hi, lo} - 64'(sa * sb));
                        {nhi, nlo} = acc;
                        cyc = 5;
                    end
                end
                default: ;
            endcase
        end
    endfunction

    // Issue one op for one edge, count busy cycles, check hold and final HI/LO.
    task automatic run_op(input string name, input logic [2:0] op, input bit st,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int exp_cycles);
        int cycles = 0;
        bit held = 1'b1;
        @(negedge clk);
        MDop  = op;
        A     = a;
        B     = b;
        start = st;
        @(negedge clk);
        start = 1'b0;
        MDop  = 3'd0;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            if (HI !== hi_m || LO !== lo_m) held = 1'b0;
            @(negedge clk);
        end
        check({name, " busy cycles"}, 64'(cycles), 64'(exp_cycles));
        if (exp_cycles > 0) check({name, " HI/LO hold while busy"}, 64'(held), 64'd1);
        check({name, " HI"}, 64'(HI), 64'(exp_hi));
        check({name, " LO"}, 64'(LO), 64'(exp_lo));
        hi_m = exp_hi;
        lo_m = exp_lo;
    endtask

    initial begin
        int          cycles;
        logic [2:0]  op;
        bit          st;
        logic [31:0] a, b, eh, el;
        int          ec;

        vecs[0] = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{3'd3, 32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[6] = '{3'd3, 32'hFFFFFFFF, 32'd10,       32'h00000005, 32'h19999999, 10};
        vecs[7] = '{3'd1, 32'd0,        32'd0,        32'h00000000, 32'h00000000, 5};

        reset = 1'b1;
        start = 1'b0;
        MDop  = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset HI", 64'(HI), 64'd0);
        check("reset LO", 64'(LO), 64'd0);

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].op, 1'b1, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].cycles);

        // mthi while idle, no start needed
        run_op("mthi idle", 3'd4, 1'b0, 32'h1234, 32'd0, 32'h1234, lo_m, 0);

        // mtlo and a second start during a div are both ignored
        @(negedge clk);
        MDop  = 3'd2;
        A     = 32'd100;
        B     = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            case (cycles)
                1: begin MDop = 3'd5; A = 32'hDEAD; end
                2: begin
                    check("mtlo while busy LO", 64'(LO), 64'(lo_m));
                    MDop = 3'd0; A = 32'd3; B = 32'd3; start = 1'b1;
                end
                3: start = 1'b0;
                default: ;
            endcase
            @(negedge clk);
        end
        check("div with overlap busy cycles", 64'(cycles), 64'd10);
        check("div with overlap HI", 64'(HI), 64'd2);
        check("div with overlap LO", 64'(LO), 64'd14);
        @(negedge clk);
        check("overlap start not queued", 64'(busy), 64'd0);
        hi_m = 32'd2;
        lo_m = 32'd14;

        // reset at cycle 4 of a div
        MDop  = 3'd2;
        A     = 32'd1000;
        B     = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid-op reset busy", 64'(busy), 64'd0);
        check("mid-op reset HI", 64'(HI), 64'd0);
        check("mid-op reset LO", 64'(LO), 64'd0);
        repeat (12) @(negedge clk);
        check("no late write HI", 64'(HI), 64'd0);
        check("no late write LO", 64'(LO), 64'd0);
        check("no late busy", 64'(busy), 64'd0);
        hi_m = 32'd0;
        lo_m = 32'd0;

        // madd/msub: active only with MDU_MADD_EN
        run_op("mthi 0", 3'd4, 1'b0, 32'd0, 32'd0, 32'd0, lo_m, 0);
        run_op("mtlo ffffffff", 3'd5, 1'b0, 32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF, 0);
        run_op("madd 1*1", 3'd6, 1'b1, 32'd1, 32'd1,
               MADD_EN ? 32'd1 : 32'd0, MADD_EN ? 32'd0 : 32'hFFFFFFFF, MADD_EN ? 5 : 0);
        run_op("msub 1*1", 3'd7, 1'b1, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, MADD_EN ? 5 : 0);

        // randomized ops against the reference model
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            st = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       a = 32'h80000000;
                1:       a = 32'($urandom_range(0, 50));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            model(op, st, a, b, hi_m, lo_m, eh, el, ec);
            run_op($sformatf("rand%0d op%0d st%0d", n, op, st), op, st, a, b, eh, el, ec);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
